// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, point constants and score saturation helper
package game_pkg;

   typedef enum logic {PLAY, TALLY} game_state_t;

   localparam int PICKUP_PTS = 100;
   localparam int NET_PTS    = 500;
   localparam int SCORE_MAX  = 999_999;

   // Sums are carried in 25 bits so a carry out of the 24-bit score is never lost
   function automatic logic [23:0] sat_score(input logic [24:0] sum);
      return (sum > 25'(SCORE_MAX)) ? 24'(SCORE_MAX) : sum[23:0];
   endfunction

endpackage

// File: rtl/score_management_unit_if.sv
// rtl/score_management_unit_if.sv - event inputs and score outputs of the score unit
interface score_management_unit_if;

   logic        pickup;
   logic        net_hit;
   logic        hero_rst;
   logic        freeze;
   logic [23:0] score;
   logic [15:0] bonus;
   logic        tally_busy;

   modport master (
      output pickup, net_hit, hero_rst, freeze,
      input  score, bonus, tally_busy
   );

   modport slave (
      input  pickup, net_hit, hero_rst, freeze,
      output score, bonus, tally_busy
   );

endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - CLK_DIV counter with enable and clear, emits a one-cycle tick on wrap
module tick_gen #(
   parameter int CLK_DIV = 65_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int              W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0]    LAST = W'(CLK_DIV - 1);

   logic [W-1:0] r_cnt;

   assign o_tick = i_en && !i_clr && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/score_management_unit.sv
// rtl/score_management_unit.sv - running score, per-level time bonus and end-of-level bonus tally
module score_management_unit
   import game_pkg::*;
#(
   parameter int CLK_DIV     = 65_000_000,
   parameter int BONUS_START = 5000,
   parameter int BONUS_STEP  = 10,
   parameter int TALLY_STEP  = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   score_management_unit_if.slave  bus
);

   game_state_t r_state;
   logic [23:0] r_score;
   logic [15:0] r_bonus;
   logic        r_tally_busy;

   logic        w_tick;
   logic        w_tick_en;
   logic        w_tick_clr;
   logic [24:0] w_evt_sum;
   logic [15:0] w_xfer;
   logic [24:0] w_tally_sum;

   assign w_tick_en  = (r_state == PLAY) && !bus.freeze;
   // Counter is held at zero through the tally so the next level starts on a full second
   assign w_tick_clr = (r_state == TALLY) || bus.hero_rst;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst),
      .i_en   (w_tick_en),
      .i_clr  (w_tick_clr),
      .o_tick (w_tick)
   );

   assign w_evt_sum   = {1'b0, r_score}
                      + (bus.pickup  ? 25'(PICKUP_PTS) : 25'd0)
                      + (bus.net_hit ? 25'(NET_PTS)    : 25'd0);
   assign w_xfer      = (r_bonus > 16'(TALLY_STEP)) ? 16'(TALLY_STEP) : r_bonus;
   assign w_tally_sum = {1'b0, r_score} + {9'd0, w_xfer};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= PLAY;
         r_score      <= '0;
         r_bonus      <= 16'(BONUS_START);
         r_tally_busy <= 1'b0;
      end else begin
         case (r_state)
            PLAY: begin
               r_score <= sat_score(w_evt_sum);
               if (w_tick) begin
                  r_bonus <= (r_bonus > 16'(BONUS_STEP)) ? r_bonus - 16'(BONUS_STEP) : 16'd0;
               end
               if (bus.hero_rst) begin
                  r_state      <= TALLY;
                  r_tally_busy <= 1'b1;
               end
            end
            TALLY: begin
               if (r_bonus == 16'd0) begin
                  r_state      <= PLAY;
                  r_bonus      <= 16'(BONUS_START);
                  r_tally_busy <= 1'b0;
               end else begin
                  r_bonus <= r_bonus - w_xfer;
                  r_score <= sat_score(w_tally_sum);
               end
            end
            default: r_state <= PLAY;
         endcase
      end
   end

   assign bus.score      = r_score;
   assign bus.bonus      = r_bonus;
   assign bus.tally_busy = r_tally_busy;

endmodule

// File: tb/tb_score_management_unit.sv
// tb/tb_score_management_unit.sv - directed self-checking bench for score_management_unit
module tb_score_management_unit;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   score_management_unit_if bus ();

   score_management_unit #(
      .CLK_DIV     (4),
      .BONUS_START (50),
      .BONUS_STEP  (10),
      .TALLY_STEP  (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      bus.pickup = 0; bus.net_hit = 0; bus.hero_rst = 0; bus.freeze = 0;
      rst = 0;
      #12;
      checks++;
      if (bus.score !== 24'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", bus.score); end
      checks++;
      if (bus.bonus !== 16'd50) begin errors++; $display("FAIL reset_bonus got=%0d exp=50", bus.bonus); end
      checks++;
      if (bus.tally_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.tally_busy); end
   endtask

   task automatic test_countdown();
      int exp_b;
      @(negedge clk) rst = 1;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         exp_b = 50 - 10 * (n / 4);
         if (exp_b < 0) exp_b = 0;
         checks++;
         if (bus.bonus !== 16'(exp_b)) begin
            errors++; $display("FAIL countdown_bonus n=%0d got=%0d exp=%0d", n, bus.bonus, exp_b);
         end
      end
      checks++;
      if (bus.score !== 24'd0) begin errors++; $display("FAIL countdown_score got=%0d exp=0", bus.score); end
   endtask

   task automatic test_events();
      test_reset();
      bus.freeze = 1;
      @(negedge clk) rst = 1;
      @(negedge clk) begin bus.pickup = 1; bus.net_hit = 1; end
      @(negedge clk) begin bus.pickup = 0; bus.net_hit = 0; end
      checks++;
      if (bus.score !== 24'd600) begin errors++; $display("FAIL events_both got=%0d exp=600", bus.score); end
      bus.pickup = 1;
      @(negedge clk);
      checks++;
      if (bus.score !== 24'd700) begin errors++; $display("FAIL events_pick1 got=%0d exp=700", bus.score); end
      @(negedge clk) bus.pickup = 0;
      checks++;
      if (bus.score !== 24'd800) begin errors++; $display("FAIL events_pick2 got=%0d exp=800", bus.score); end
   endtask

   task automatic run_tally(input int s0, input int s1, input int s2, input int s3);
      int exp_s[3];
      int exp_b[3];
      exp_s[0] = s1; exp_s[1] = s2; exp_s[2] = s3;
      exp_b[0] = 30; exp_b[1] = 10; exp_b[2] = 0;
      @(negedge clk) bus.hero_rst = 1;
      @(negedge clk) bus.hero_rst = 0;
      checks++;
      if (bus.tally_busy !== 1'b1 || bus.score !== 24'(s0) || bus.bonus !== 16'd50) begin
         errors++; $display("FAIL tally_entry busy=%b score=%0d bonus=%0d exp busy=1 score=%0d bonus=50",
                            bus.tally_busy, bus.score, bus.bonus, s0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.score !== 24'(exp_s[i]) || bus.bonus !== 16'(exp_b[i]) || bus.tally_busy !== 1'b1) begin
            errors++; $display("FAIL tally_step%0d score=%0d bonus=%0d busy=%b exp score=%0d bonus=%0d busy=1",
                               i, bus.score, bus.bonus, bus.tally_busy, exp_s[i], exp_b[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.bonus !== 16'd50 || bus.tally_busy !== 1'b0 || bus.score !== 24'(s3)) begin
         errors++; $display("FAIL tally_exit bonus=%0d busy=%b score=%0d exp bonus=50 busy=0 score=%0d",
                            bus.bonus, bus.tally_busy, bus.score, s3);
      end
   endtask

   task automatic test_tally();
      run_tally(800, 820, 840, 850);
   endtask

   task automatic test_freeze();
      bus.freeze = 1;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.bonus !== 16'd50) begin errors++; $display("FAIL freeze_bonus got=%0d exp=50", bus.bonus); end
      bus.pickup = 1;
      @(negedge clk) bus.pickup = 0;
      checks++;
      if (bus.score !== 24'd950) begin errors++; $display("FAIL freeze_pickup got=%0d exp=950", bus.score); end
   endtask

   task automatic test_saturation();
      bus.net_hit = 1;
      repeat (1998) @(negedge clk);
      bus.net_hit = 0;
      checks++;
      if (bus.score !== 24'd999_950) begin errors++; $display("FAIL sat_preload got=%0d exp=999950", bus.score); end
      bus.net_hit = 1;
      @(negedge clk) bus.net_hit = 0;
      checks++;
      if (bus.score !== 24'd999_999) begin errors++; $display("FAIL sat_clip got=%0d exp=999999", bus.score); end
      run_tally(999_999, 999_999, 999_999, 999_999);
   endtask

   task automatic test_reset_mid_tally();
      bus.freeze = 0;
      @(negedge clk) bus.hero_rst = 1;
      @(negedge clk) bus.hero_rst = 0;
      @(posedge clk);
      #2 rst = 0;
      #1;
      checks++;
      if (bus.score !== 24'd0 || bus.bonus !== 16'd50 || bus.tally_busy !== 1'b0) begin
         errors++; $display("FAIL async_reset score=%0d bonus=%0d busy=%b exp 0/50/0",
                            bus.score, bus.bonus, bus.tally_busy);
      end
      @(negedge clk) rst = 1;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.bonus !== 16'd40) begin errors++; $display("FAIL resume_tick1 got=%0d exp=40", bus.bonus); end
      repeat (4) @(negedge clk);
      checks++;
      if (bus.bonus !== 16'd30 || bus.tally_busy !== 1'b0) begin
         errors++; $display("FAIL resume_tick2 bonus=%0d busy=%b exp 30/0", bus.bonus, bus.tally_busy);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_countdown();
      test_events();
      test_tally();
      test_freeze();
      test_saturation();
      test_reset_mid_tally();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_management_unit.md
Name: score_management_unit

Overview:
- Produces the 24-bit running score consumed by level_management_unit.
- Accumulates gameplay event points and runs a per-level time bonus that counts down once per second.
- When level_management_unit pulses hero_rst (level complete), the remaining bonus is tallied into the score over several cycles.
- Sits between the event/collision logic (upstream) and level_management_unit plus the score display (downstream).

Parameters:
- CLK_DIV, 65_000_000, clk cycles per bonus tick (1 s at 65 MHz).
- BONUS_START, 5000, time bonus loaded at reset and at the start of each level.
- BONUS_STEP, 10, amount removed from the bonus per tick.
- PICKUP_PTS, 100, points per pickup pulse.
- NET_PTS, 500, points per net_hit pulse.
- TALLY_STEP, 10, maximum bonus moved into the score per cycle during tally.
- SCORE_MAX, 999_999, score saturation ceiling.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pickup  in  1  one-cycle pulse: item collected.
- net_hit  in  1  one-cycle pulse: enemy trapped in net.
- hero_rst  in  1  one-cycle pulse from level_management_unit: level complete.
- freeze  in  1  pause; holds tick counter and bonus while high.
- score  out  24  running score, binary.
- bonus  out  16  remaining time bonus, binary.
- tally_busy  out  1  high while the bonus is being transferred.

Behaviour:
- Reset (rst low, async): score=0, bonus=BONUS_START, tally_busy=0, tick counter=0, state=PLAY. All outputs are registered.
- States: PLAY, TALLY.
- PLAY, events:
  - score_next = min(score + pickup·PICKUP_PTS + net_hit·NET_PTS, SCORE_MAX).
  - Simultaneous pickup and net_hit add both values in the same cycle.
  - Result appears on score one cycle after the pulse.
  - Freeze does not block event points.
- PLAY, tick:
  - The counter increments each cycle when freeze=0.
  - At CLK_DIV-1 it wraps to 0 and bonus = (bonus > BONUS_STEP) ? bonus - BONUS_STEP : 0.
  - The bonus never goes negative or wraps.
- PLAY -> TALLY on hero_rst=1:
  - tally_busy=1 from the next cycle.
  - Tick counter cleared.
  - Any event pulse in the same cycle is still scored.
- TALLY, each cycle:
  - xfer = min(TALLY_STEP, bonus).
  - bonus -= xfer; score = min(score + xfer, SCORE_MAX).
  - Once saturated, the bonus still drains.
  - pickup, net_hit, freeze and hero_rst are ignored.
- TALLY -> PLAY when bonus is 0 at the start of a cycle:
  - That cycle loads bonus=BONUS_START and clears tally_busy.
  - Tick counter restarts from 0.
  - With bonus=0 on entry, the tally lasts exactly one cycle.
- Ordering: the score only increases between resets. Because level_management_unit compares score against score_req in the cycle hero_rst is generated, that compare always sees the pre-tally score.
- Reset mid-tally aborts immediately to the reset values.
- Width rules:
  - Score adds use 25-bit intermediates before the saturation compare.
  - bonus is 16 bits; BONUS_START must be ≤ 65535.
  - Tick counter width is clog2(CLK_DIV).

Decomposition:
- Shared package game_pkg holds:
  - the state enum (PLAY, TALLY);
  - the point constants PICKUP_PTS and NET_PTS;
  - SCORE_MAX, which level_management_unit also uses for its score_req arithmetic.
- One natural sub-module: tick_gen, a CLK_DIV counter with enable that emits a one-cycle tick. It is reusable by enemy movement timing.

Test Plan (CLK_DIV=4, BONUS_START=50, BONUS_STEP=10, TALLY_STEP=20):
- Release reset, no events, freeze=0 for 24 cycles -> bonus steps 50,40,30,20,10,0 every 4 cycles, then holds at 0; score=0.
- Pickup and net_hit pulsed together once -> score=600 next cycle; pickup alone twice more -> 800.
- Score=800, bonus=50, hero_rst pulse -> tally_busy=1; score 820,840,850 over three cycles; bonus 30,10,0; next cycle bonus=50, tally_busy=0.
- freeze=1 for 20 cycles in PLAY -> bonus unchanged at 50; pickup during freeze -> +100 still applied.
- Preload score to 999_950 via events (SCORE_MAX=999_999), then net_hit -> score=999_999; hero_rst tally -> score stays 999_999, bonus drains to 0, reloads 50.
- Assert rst low during the second tally cycle -> score=0, bonus=50, tally_busy=0 asynchronously, without waiting for a clk edge; normal ticking resumes after release.
